// File: rtl/bitsliced_serial_adder_pkg.sv
// Shared types and elaboration helpers for the bit-sliced serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Bit-plane index width; a single-plane adder still needs a 1-bit counter.
    function automatic int idx_width(input int nbits);
        return (nbits <= 1) ? 1 : $clog2(nbits);
    endfunction

endpackage

// File: rtl/bitslice_full_adder.sv
// LANES independent full adders: one bit plane of sum and carry per call.
module bitslice_full_adder #(
    parameter int LANES = 16
) (
    input  logic [LANES-1:0] x,
    input  logic [LANES-1:0] y,
    input  logic [LANES-1:0] cin,
    output logic [LANES-1:0] s,
    output logic [LANES-1:0] cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/bitsliced_serial_adder.sv
// Bit-serial add/subtract over bit-sliced operands: one bit plane per clock,
// LANES independent fitness cases in parallel, valid/ready on both sides.
module bitsliced_serial_adder
    import adder_pkg::*;
#(
    parameter int LANES = 16,
    parameter int NBITS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        sub,
    input  logic [NBITS-1:0][LANES-1:0] a,
    input  logic [NBITS-1:0][LANES-1:0] b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NBITS:0][LANES-1:0]   y,
    output logic                        busy
);

    localparam int IW = idx_width(NBITS);

    if (NBITS < 1 || LANES < 1) begin : g_param_check
        $error("bitsliced_serial_adder: NBITS and LANES must both be >= 1");
    end

    state_t                      state;
    logic [IW-1:0]               idx;
    logic [LANES-1:0]            carry;
    logic [NBITS-1:0][LANES-1:0] a_r;
    logic [NBITS-1:0][LANES-1:0] b_r;
    logic [NBITS-1:0][LANES-1:0] b_eff;
    logic [LANES-1:0]            a_bit;
    logic [LANES-1:0]            b_bit;
    logic [LANES-1:0]            fa_s;
    logic [LANES-1:0]            fa_c;
    logic                        last;

    // Subtraction is a + ~b + 1: invert B here, the +1 enters as the initial carry.
    always_comb begin
        for (int k = 0; k < NBITS; k++) begin
            b_eff[k] = b[k] ^ {LANES{sub}};
        end
    end

    // NOTE: every variable gets a default before the loop, otherwise a plane
    // not matched by idx would hold its value and infer a latch.
    always_comb begin
        a_bit = '0;
        b_bit = '0;
        for (int k = 0; k < NBITS; k++) begin
            if (idx == IW'(k)) begin
                a_bit = a_r[k];
                b_bit = b_r[k];
            end
        end
    end

    assign last = (idx == IW'(NBITS - 1));

    bitslice_full_adder #(
        .LANES(LANES)
    ) u_fa (
        .x   (a_bit),
        .y   (b_bit),
        .cin (carry),
        .s   (fa_s),
        .cout(fa_c)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= '0;
            y     <= '0;
            a_r   <= '0;
            b_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b_eff;
                        carry <= {LANES{sub}};
                        idx   <= '0;
                        y     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NBITS; k++) begin
                        if (idx == IW'(k)) begin
                            y[k] <= fa_s;
                        end
                    end
                    carry <= fa_c;
                    if (last) begin
                        y[NBITS] <= fa_c;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitsliced_serial_adder.sv
// Scoreboard bench for bitsliced_serial_adder: NBITS=2 and NBITS=5 instances.
module tb_bitsliced_serial_adder;

    localparam int L = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // NBITS = 2 instance
    logic              in_valid, in_ready, sub, out_valid, out_ready, busy;
    logic [1:0][L-1:0] a, b;
    logic [2:0][L-1:0] y;

    // NBITS = 5 instance
    logic              in_valid5, in_ready5, sub5, out_valid5, out_ready5, busy5;
    logic [4:0][L-1:0] a5, b5;
    logic [5:0][L-1:0] y5;

    bitsliced_serial_adder #(.LANES(L), .NBITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
    );

    bitsliced_serial_adder #(.LANES(L), .NBITS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .sub(sub5), .a(a5), .b(b5), .out_valid(out_valid5), .out_ready(out_ready5),
        .y(y5), .busy(busy5)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] q2[$];
    logic [95:0] q5[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    // Scalar reference: rebuild each lane's integers, do the arithmetic, re-slice.
    function automatic logic [5:0][L-1:0] model5(input logic s,
                                                 input logic [4:0][L-1:0] av_p,
                                                 input logic [4:0][L-1:0] bv_p);
        logic [5:0][L-1:0] r;
        int av, bv, res;
        r = '0;
        for (int l = 0; l < L; l++) begin
            av = 0;
            bv = 0;
            for (int k = 0; k < 5; k++) begin
                av += int'(av_p[k][l]) << k;
                bv += int'(bv_p[k][l]) << k;
            end
            if (s) res = ((av - bv) & 31) | ((av >= bv) ? 32 : 0);
            else   res = av + bv;
            for (int k = 0; k < 6; k++) r[k][l] = res[k];
        end
        return r;
    endfunction

    // Monitors: pop and compare whenever a result is handed over.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q2.size() == 0) fail_now("n2 unexpected result");
            else check("n2 result", y, q2.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid5 && out_ready5) begin
            if (q5.size() == 0) fail_now("n5 unexpected result");
            else check("n5 result", y5, q5.pop_front());
        end
    end

    task automatic wait_ready2();
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) fail_now("n2 in_ready timeout");
    endtask

    task automatic wait_ready5();
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready5) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) fail_now("n5 in_ready timeout");
    endtask

    task automatic issue2(input logic s, input logic [1:0][L-1:0] av, input logic [1:0][L-1:0] bv,
                          input logic [47:0] exp);
        wait_ready2();
        sub = s; a = av; b = bv; in_valid = 1'b1;
        q2.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue5(input logic s, input logic [4:0][L-1:0] av, input logic [4:0][L-1:0] bv,
                          input logic [95:0] exp);
        wait_ready5();
        sub5 = s; a5 = av; b5 = bv; in_valid5 = 1'b1;
        q5.push_back(exp);
        @(posedge clk); #1;
        in_valid5 = 1'b0;
    endtask

    localparam logic [47:0] EXP_MAX  = {16'hFFFF, 16'hFFFF, 16'h0000};
    localparam logic [47:0] EXP_EXH  = {16'hEC80, 16'h936C, 16'h5A5A};
    localparam logic [47:0] EXP_SUB  = {16'h0000, 16'hFFFF, 16'hFFFF};
    localparam logic [47:0] EXP_SUB2 = {16'hFFFF, 16'hFFFF, 16'h0000};

    initial begin
        logic [4:0][L-1:0] pa, pb;
        bit seen;

        in_valid = 0; sub = 0; a = '0; b = '0; out_ready = 1;
        in_valid5 = 0; sub5 = 0; a5 = '0; b5 = '0; out_ready5 = 1;

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        check("reset y", y, 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset n5 y", y5, 0);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", in_ready, 1);

        // 2: max add with latency check
        issue2(0, {16'hFFFF, 16'hFFFF}, {16'hFFFF, 16'hFFFF}, EXP_MAX);
        @(negedge clk);
        check("latency E", out_valid, 0);
        @(posedge clk); @(negedge clk);
        check("latency E+1", out_valid, 0);
        @(posedge clk); @(negedge clk);
        check("latency E+2", out_valid, 1);
        @(posedge clk); #1;
        check("y retained in IDLE", y, EXP_MAX);
        check("in_ready after handshake", in_ready, 1);

        // 3: every (a,b) pair across the lanes
        issue2(0, {16'hFF00, 16'hF0F0}, {16'hCCCC, 16'hAAAA}, EXP_EXH);

        // 4: subtract with borrow
        issue2(1, {16'hFFFF, 16'h0000}, {16'hFFFF, 16'hFFFF}, EXP_SUB);

        // 5: backpressure; 3-1 = 2, no borrow
        wait_ready2();
        out_ready = 0;
        issue2(1, {16'hFFFF, 16'hFFFF}, {16'h0000, 16'hFFFF}, EXP_SUB2);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) fail_now("backpressure out_valid timeout");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i == 2);
            sub = 0; a = '0; b = '0;
            @(negedge clk);
            check("bp y held", y, EXP_SUB2);
            check("bp in_ready low", in_ready, 0);
            check("bp out_valid held", out_valid, 1);
        end
        // Handshake and new in_valid in the same cycle: accepted one cycle later.
        @(posedge clk); #1;
        out_ready = 1;
        in_valid = 1; sub = 0;
        a = {16'hFFFF, 16'hFFFF}; b = {16'hFFFF, 16'hFFFF};
        q2.push_back(EXP_MAX);
        @(negedge clk);
        check("hs cycle in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("after hs idle", busy, 0);
        check("after hs in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("accepted next cycle", busy, 1);
        in_valid = 0;

        // 6: reset mid-RUN
        wait_ready2();
        sub = 0; a = {16'hFF00, 16'hF0F0}; b = {16'hCCCC, 16'hAAAA}; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort y", y, 0);
        check("abort busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1;
        issue2(0, {16'hFFFF, 16'hFFFF}, {16'hFFFF, 16'hFFFF}, EXP_MAX);

        // NBITS = 5
        issue5(0, {5{16'hFFFF}}, {5{16'hFFFF}},
               {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000});
        pa = {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 16'h5555};
        pb = {16'h0F0F, 16'h3333, 16'hFFFF, 16'h00FF, 16'h9999};
        issue5(0, pa, pb, model5(0, pa, pb));
        issue5(1, pa, pb, model5(1, pa, pb));
        issue5(1, pb, pa, model5(1, pb, pa));

        // Drain both scoreboards
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (q2.size() == 0 && q5.size() == 0 && !busy && !busy5) seen = 1;
        end
        if (!seen) fail_now("drain timeout");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
